gddr6_ca_encoder: RTL

- Controller-side GDDR6 command/address encoder; the transmit end of the CA bus that the channel checker decodes.
- Accepts abstract commands over a valid/ready handshake and enforces per-bank state plus tRCD/tRP/tCCD_S/tCCD_L spacing in CLK_t cycles.
- Emits per-cycle rising-half and falling-half 11-bit CA words, with optional CABI, to the DDR PHY serializer.

---
 rtl/gddr6_pkg.sv | 81 ++++++++
 rtl/gddr6_cabi_enc.sv | 34 +++
 rtl/gddr6_ca_encoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gddr6_pkg.sv
// Shared GDDR6 CA encoder types, field positions and word encoding.
// CA inversion is built only with GDDR6_CABI_EN (see gddr6_cabi_enc).
package gddr6_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ACT   = 3'd1,
    OP_RD    = 3'd2,
    OP_RDA   = 3'd3,
    OP_PREPB = 3'd4,
    OP_PREAB = 3'd5,
    OP_ILL6  = 3'd6,
    OP_ILL7  = 3'd7
  } cmd_op_e;

  localparam int CA_W   = 11;
  localparam int OPC_HI = 9;
  localparam int OPC_LO = 8;
  localparam int F_AP   = 4;
  localparam int F_AB   = 3;

  localparam logic [1:0] OPC_R_NOP = 2'b11;
  localparam logic [1:0] OPC_F_NOP = 2'b11;
  localparam logic [1:0] OPC_R_RD  = 2'b11;
  localparam logic [1:0] OPC_F_RD  = 2'b01;
  localparam logic [1:0] OPC_R_PRE = 2'b10;
  localparam logic [1:0] OPC_F_PRE = 2'b00;

  localparam logic [CA_W-1:0] NOP_RISE = 11'h300;
  localparam logic [CA_W-1:0] NOP_FALL = 11'h300;

  localparam int CABI_ZERO_TH = 5;

  typedef struct packed {
    logic [CA_W-1:0] rise;
    logic [CA_W-1:0] fall;
  } ca_pair_t;

  function automatic ca_pair_t ca_encode(
    input cmd_op_e     op,
    input logic [3:0]  bank,
    input logic [14:0] row,
    input logic [6:0]  col
  );
    ca_pair_t p;
    p.rise = '0;
    p.fall = '0;
    case (op)
      OP_ACT: begin
        p.rise[8]   = row[14];
        p.rise[7:4] = bank;
        p.rise[3:0] = row[3:0];
        p.fall[9:0] = row[13:4];
      end
      OP_RD, OP_RDA: begin
        p.rise[OPC_HI:OPC_LO] = OPC_R_RD;
        p.rise[7:4]           = bank;
        p.rise[3:0]           = col[3:0];
        p.fall[OPC_HI:OPC_LO] = OPC_F_RD;
        p.fall[2:0]           = col[6:4];
        p.fall[F_AP]          = (op == OP_RDA);
      end
      OP_PREPB: begin
        p.rise[OPC_HI:OPC_LO] = OPC_R_PRE;
        p.rise[7:4]           = bank;
        p.fall[OPC_HI:OPC_LO] = OPC_F_PRE;
      end
      OP_PREAB: begin
        p.rise[OPC_HI:OPC_LO] = OPC_R_PRE;
        p.fall[OPC_HI:OPC_LO] = OPC_F_PRE;
        p.fall[F_AB]          = 1'b1;
      end
      default: begin
        p.rise[OPC_HI:OPC_LO] = OPC_R_NOP;
        p.fall[OPC_HI:OPC_LO] = OPC_F_NOP;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/gddr6_cabi_enc.sv
// Zero-count CA bus inversion for one 11-bit word.
// Active only when GDDR6_CABI_EN is defined; otherwise a pass-through.
module gddr6_cabi_enc
  import gddr6_pkg::*;
(
  input  logic            en,
  input  logic [CA_W-1:0] word,
  output logic [CA_W-1:0] ca,
  output logic            cabi_n
);

`ifdef GDDR6_CABI_EN
  logic [3:0] zeros;
  logic       inv;

  always_comb begin
    zeros = '0;
    for (int i = 0; i < CA_W; i++) begin
      zeros = zeros + {3'b000, ~word[i]};
    end
  end

  assign inv    = en && (zeros > 4'(CABI_ZERO_TH));
  assign ca     = inv ? ~word : word;
  assign cabi_n = ~inv;
`else
  logic en_unused;

  assign en_unused = en;
  assign ca        = word;
  assign cabi_n    = 1'b1;
`endif

endmodule

// File: rtl/gddr6_ca_encoder.sv
// GDDR6 command/address encoder: one-entry hold, bank state, CA timing.
// Optional CA inversion is compiled in with GDDR6_CABI_EN.
module gddr6_ca_encoder
  import gddr6_pkg::*;
#(
  parameter int TCCD_S = 2,
  parameter int TCCD_L = 4,
  parameter int TRCD   = 12,
  parameter int TRP    = 12,
  parameter int CNT_W  = 5
) (
  input  logic            CLK_t,
  input  logic            RESET,
  input  logic            mr3_bg_en,
  input  logic            mr1_cabi_en,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [3:0]      cmd_bank,
  input  logic [14:0]     cmd_row,
  input  logic [6:0]      cmd_col,
  output logic [CA_W-1:0] ca_rise,
  output logic [CA_W-1:0] ca_fall,
  output logic            cabi_n_rise,
  output logic            cabi_n_fall,
  output logic            cmd_err,
  output logic [15:0]     bank_open
);

  localparam logic [CNT_W-1:0] TCCD_S_C = CNT_W'(TCCD_S);
  localparam logic [CNT_W-1:0] TCCD_L_C = CNT_W'(TCCD_L);
  localparam logic [CNT_W-1:0] TRCD_C   = CNT_W'(TRCD);
  localparam logic [CNT_W-1:0] TRP_C    = CNT_W'(TRP);

  typedef enum logic {S_EMPTY, S_HELD} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e      state;
  cmd_op_e     h_op;
  logic [3:0]  h_bank;
  logic [14:0] h_row;
  logic [6:0]  h_col;
  logic [1:0]  h_grp;

  logic [CNT_W-1:0] rcd_cnt [16];
  logic [CNT_W-1:0] rp_cnt  [16];
  logic [CNT_W-1:0] bg_cnt  [4];
  logic [CNT_W-1:0] glb_cnt;

  cmd_op_e req_op;
  logic    accept;
  logic    req_bad;
  logic    timing_ok;
  logic    issue;

  logic act_iss;
  logic rd_iss;
  logic pre_one_iss;
  logic pre_all_iss;

  ca_pair_t        enc;
  logic [CA_W-1:0] rise_c;
  logic [CA_W-1:0] fall_c;
  logic            cabi_r_c;
  logic            cabi_f_c;

  logic [CNT_W-1:0] rcd_n;
  logic [CNT_W-1:0] rp_n;
  logic [CNT_W-1:0] bg_n;
  logic [CNT_W-1:0] glb_n;

  assign req_op = cmd_op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready;
  assign h_grp  = h_bank[3:2];

  always_comb begin
    req_bad = 1'b0;
    case (req_op)
      OP_ACT:           req_bad = bank_open[cmd_bank];
      OP_RD, OP_RDA:    req_bad = !bank_open[cmd_bank];
      OP_ILL6, OP_ILL7: req_bad = 1'b1;
      default:          req_bad = 1'b0;
    endcase
  end

  // Spacing is judged on the count as it will read in the issue cycle.
  assign rcd_n = sat_inc(rcd_cnt[h_bank]);
  assign rp_n  = sat_inc(rp_cnt[h_bank]);
  assign bg_n  = sat_inc(bg_cnt[h_grp]);
  assign glb_n = sat_inc(glb_cnt);

  always_comb begin
    timing_ok = 1'b1;
    case (h_op)
      OP_ACT: timing_ok = (rp_n >= TRP_C);
      OP_RD, OP_RDA: begin
        timing_ok = (rcd_n >= TRCD_C)
                 && (glb_n >= TCCD_S_C)
                 && (!mr3_bg_en || bg_n >= TCCD_L_C);
      end
      default: timing_ok = 1'b1;
    endcase
  end

  assign issue = (state == S_HELD) && timing_ok;

  assign act_iss     = issue && (h_op == OP_ACT);
  assign rd_iss      = issue && (h_op == OP_RD || h_op == OP_RDA);
  assign pre_one_iss = issue && (h_op == OP_RDA || h_op == OP_PREPB);
  assign pre_all_iss = issue && (h_op == OP_PREAB);

  assign enc = ca_encode(issue ? h_op : OP_NOP, h_bank, h_row, h_col);

  gddr6_cabi_enc u_cabi_rise (
    .en     (mr1_cabi_en),
    .word   (enc.rise),
    .ca     (rise_c),
    .cabi_n (cabi_r_c)
  );

  gddr6_cabi_enc u_cabi_fall (
    .en     (mr1_cabi_en),
    .word   (enc.fall),
    .ca     (fall_c),
    .cabi_n (cabi_f_c)
  );

  always_ff @(posedge CLK_t or posedge RESET) begin
    if (RESET) begin
      for (int b = 0; b < 16; b++) begin
        rcd_cnt[b] <= '1;
        rp_cnt[b]  <= '1;
      end
      for (int g = 0; g < 4; g++) begin
        bg_cnt[g] <= '1;
      end
      glb_cnt <= '1;
    end else begin
      for (int b = 0; b < 16; b++) begin
        rcd_cnt[b] <= (act_iss && h_bank == 4'(b))
                    ? '0 : sat_inc(rcd_cnt[b]);
        rp_cnt[b]  <= (pre_all_iss ||
                       (pre_one_iss && h_bank == 4'(b)))
                    ? '0 : sat_inc(rp_cnt[b]);
      end
      for (int g = 0; g < 4; g++) begin
        bg_cnt[g] <= (rd_iss && h_grp == 2'(g))
                   ? '0 : sat_inc(bg_cnt[g]);
      end
      glb_cnt <= rd_iss ? '0 : sat_inc(glb_cnt);
    end
  end

  always_ff @(posedge CLK_t or posedge RESET) begin
    if (RESET) begin
      state       <= S_EMPTY;
      cmd_ready   <= 1'b1;
      cmd_err     <= 1'b0;
      h_op        <= OP_NOP;
      h_bank      <= '0;
      h_row       <= '0;
      h_col       <= '0;
      ca_rise     <= NOP_RISE;
      ca_fall     <= NOP_FALL;
      cabi_n_rise <= 1'b1;
      cabi_n_fall <= 1'b1;
      bank_open   <= '0;
    end else begin
      cmd_err     <= accept && req_bad;
      ca_rise     <= rise_c;
      ca_fall     <= fall_c;
      cabi_n_rise <= cabi_r_c;
      cabi_n_fall <= cabi_f_c;
      case (state)
        S_EMPTY: begin
          if (accept && !req_bad) begin
            state     <= S_HELD;
            cmd_ready <= 1'b0;
            h_op      <= req_op;
            h_bank    <= cmd_bank;
            h_row     <= cmd_row;
            h_col     <= cmd_col;
          end
        end
        S_HELD: begin
          if (issue) begin
            state     <= S_EMPTY;
            cmd_ready <= 1'b1;
            unique case (1'b1)
              (h_op == OP_ACT):
                bank_open[h_bank] <= 1'b1;
              (h_op == OP_RDA),
              (h_op == OP_PREPB):
                bank_open[h_bank] <= 1'b0;
              (h_op == OP_PREAB):
                bank_open <= '0;
              default: ;
            endcase
          end
        end
        default: begin
          state     <= S_EMPTY;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
